// File: rtl/y_mc_ctrl_if.sv
// Control bus between the y_mc_ctrl sequencer and the yIF/yID/yEX/yDM/yWB/yPC datapath.
// master = sequencer side, slave = datapath side.
interface y_mc_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      ins;
  logic             zero;
  logic             mem_ready;
  logic             int_req;
  logic             ir_we;
  logic             pc_we;
  logic             RegWrite;
  logic             ALUSrc;
  logic [2:0]       op;
  logic             MemRead;
  logic             MemWrite;
  logic             Mem2Reg;
  logic             isbranch;
  logic             isjump;
  logic             INT;
  logic             illegal;
  logic [CNT_W-1:0] retired;

  modport master (
    input  ins, zero, mem_ready, int_req,
    output ir_we, pc_we, RegWrite, ALUSrc, op, MemRead, MemWrite, Mem2Reg,
           isbranch, isjump, INT, illegal, retired
  );

  modport slave (
    output ins, zero, mem_ready, int_req,
    input  ir_we, pc_we, RegWrite, ALUSrc, op, MemRead, MemWrite, Mem2Reg,
           isbranch, isjump, INT, illegal, retired
  );
endinterface

// File: rtl/y_mc_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for a small RV32I subset.
// Controls are Moore outputs of the state and the latched opcode/funct fields;
// only int_req (FETCH) and mem_ready (MEM) feed the state-dependent outputs.
// Optional macro Y_CTRL_TRAP_EN: illegal instructions trap through INT instead of
// retiring as a NOP.
module y_mc_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  y_mc_ctrl_if.master  bus
);

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [6:0] OPC_LW  = 7'b0000011;
  localparam logic [6:0] OPC_SW  = 7'b0100011;
  localparam logic [6:0] OPC_BEQ = 7'b1100011;
  localparam logic [6:0] OPC_JAL = 7'b1101111;

  state_t           state, nstate;
  logic [6:0]       opc_q;
  logic [2:0]       f3_q;
  logic             f7_q;
  logic [CNT_W-1:0] retired_q;

  logic       is_alu, is_lw, is_sw, is_beq, is_jal;
  logic [2:0] alu_op;
  logic       alu_src;
  logic       retire;

  // Only opcode, funct3 and funct7[5] matter here; rs/rd/imm go to the datapath.
  logic unused_bits;
  assign unused_bits = &{1'b0, bus.zero, bus.ins[31], bus.ins[29:15], bus.ins[11:7]};

  // Maps funct3 (and the sub bit) to {legal, yAlu op}.
  function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic sub);
    case (f3)
      3'b000:  alu_decode = sub ? 4'b1110 : 4'b1010;
      3'b111:  alu_decode = 4'b1000;
      3'b110:  alu_decode = 4'b1001;
      3'b010:  alu_decode = 4'b1111;
      default: alu_decode = 4'b0000;
    endcase
  endfunction

  // Instruction class and ALU controls from the latched fields.
  always_comb begin
    logic [3:0] d;
    is_alu  = 1'b0;
    is_lw   = 1'b0;
    is_sw   = 1'b0;
    is_beq  = 1'b0;
    is_jal  = 1'b0;
    alu_op  = 3'b000;
    alu_src = 1'b0;
    d       = 4'b0000;
    case (opc_q)
      OPC_R: begin
        d      = alu_decode(f3_q, f7_q);
        is_alu = d[3];
        alu_op = d[2:0];
      end
      OPC_I: begin
        d       = alu_decode(f3_q, 1'b0);
        is_alu  = d[3];
        alu_op  = d[2:0];
        alu_src = d[3];
      end
      OPC_LW: if (f3_q == 3'b010) begin
        is_lw   = 1'b1;
        alu_op  = 3'b010;
        alu_src = 1'b1;
      end
      OPC_SW: if (f3_q == 3'b010) begin
        is_sw   = 1'b1;
        alu_op  = 3'b010;
        alu_src = 1'b1;
      end
      OPC_BEQ: if (f3_q == 3'b000) begin
        is_beq = 1'b1;
        alu_op = 3'b110;
      end
      OPC_JAL: is_jal = 1'b1;
      default: ;
    endcase
  end

  // Next state and datapath controls; reset forces every control low.
  always_comb begin
    nstate       = state;
    retire       = 1'b0;
    bus.ir_we    = 1'b0;
    bus.pc_we    = 1'b0;
    bus.RegWrite = 1'b0;
    bus.ALUSrc   = 1'b0;
    bus.op       = 3'b000;
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    bus.Mem2Reg  = 1'b0;
    bus.isbranch = 1'b0;
    bus.isjump   = 1'b0;
    bus.INT      = 1'b0;
    bus.illegal  = 1'b0;
    if (rst_n) begin
      case (state)
        FETCH: begin
          if (bus.int_req) begin
            bus.INT   = 1'b1;
            bus.pc_we = 1'b1;
          end else begin
            bus.ir_we = 1'b1;
            nstate    = DECODE;
          end
        end
        DECODE: nstate = EXEC;
        EXEC: begin
          bus.op     = alu_op;
          bus.ALUSrc = alu_src;
          if (is_alu) begin
            nstate = WB;
          end else if (is_lw || is_sw) begin
            nstate = MEM;
          end else if (is_beq) begin
            bus.isbranch = 1'b1;
            bus.pc_we    = 1'b1;
            retire       = 1'b1;
            nstate       = FETCH;
          end else if (is_jal) begin
            bus.isjump = 1'b1;
            bus.pc_we  = 1'b1;
            retire     = 1'b1;
            nstate     = FETCH;
          end else begin
            bus.illegal = 1'b1;
            bus.pc_we   = 1'b1;
            nstate      = FETCH;
`ifdef Y_CTRL_TRAP_EN
            bus.INT     = 1'b1;
`else
            retire      = 1'b1;
`endif
          end
        end
        MEM: begin
          bus.op       = alu_op;
          bus.ALUSrc   = alu_src;
          bus.MemRead  = is_lw;
          bus.MemWrite = is_sw;
          if (bus.mem_ready) begin
            if (is_lw) begin
              nstate = WB;
            end else begin
              bus.pc_we = 1'b1;
              retire    = 1'b1;
              nstate    = FETCH;
            end
          end
        end
        WB: begin
          bus.op       = alu_op;
          bus.ALUSrc   = alu_src;
          bus.RegWrite = 1'b1;
          bus.Mem2Reg  = is_lw;
          bus.pc_we    = 1'b1;
          retire       = 1'b1;
          nstate       = FETCH;
        end
        default: nstate = FETCH;
      endcase
    end
  end

  // State, latched instruction fields and the retired-instruction counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= FETCH;
      opc_q     <= 7'd0;
      f3_q      <= 3'd0;
      f7_q      <= 1'b0;
      retired_q <= '0;
    end else begin
      state <= nstate;
      if (state == DECODE) begin
        opc_q <= bus.ins[6:0];
        f3_q  <= bus.ins[14:12];
        f7_q  <= bus.ins[30];
      end
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign bus.retired = retired_q;

endmodule

// File: tb/tb_y_mc_ctrl.sv
// Self-checking bench for y_mc_ctrl: per-cycle expected controls and retired
// count are queued with the stimulus and compared as the DUT produces them.
module tb_y_mc_ctrl;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  y_mc_ctrl_if #(.CNT_W(CW)) bus ();
  y_mc_ctrl #(.CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Control vector: {ir_we,pc_we,RegWrite,ALUSrc,op[2:0],MemRead,MemWrite,Mem2Reg,isbranch,isjump,INT,illegal}
  localparam logic [13:0] IRW  = 14'h2000;
  localparam logic [13:0] PCW  = 14'h1000;
  localparam logic [13:0] RW   = 14'h0800;
  localparam logic [13:0] AS   = 14'h0400;
  localparam logic [13:0] MR   = 14'h0040;
  localparam logic [13:0] MW   = 14'h0020;
  localparam logic [13:0] M2R  = 14'h0010;
  localparam logic [13:0] BR   = 14'h0008;
  localparam logic [13:0] JP   = 14'h0004;
  localparam logic [13:0] INTB = 14'h0002;
  localparam logic [13:0] ILL  = 14'h0001;

  typedef struct packed {logic rn; logic irq; logic mrdy; logic [31:0] ins;} stim_t;
  typedef logic [14+CW-1:0] obs_t;

  stim_t stim_q[$];
  obs_t  exp_q[$];
  obs_t  obs_q[$];
  int checks = 0;
  int errors = 0;
  logic [CW-1:0] exp_ret = '0;

  obs_t obs;
  assign obs = {bus.ir_we, bus.pc_we, bus.RegWrite, bus.ALUSrc, bus.op, bus.MemRead,
                bus.MemWrite, bus.Mem2Reg, bus.isbranch, bus.isjump, bus.INT, bus.illegal,
                bus.retired};

  initial begin
    bus.ins = 32'd0;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b0;
    bus.int_req = 1'b0;
  end

  function automatic logic [13:0] opf(input logic [2:0] op);
    opf = {4'b0000, op, 7'b0000000};
  endfunction

  task automatic push(input logic rn, input logic irq, input logic mrdy,
                      input logic [31:0] ins, input logic [13:0] ctl);
    stim_q.push_back({rn, irq, mrdy, ins});
    exp_q.push_back({ctl, exp_ret});
  endtask

  task automatic push_alu(input logic [31:0] ins, input logic [2:0] op, input logic src);
    logic [13:0] s;
    s = src ? AS : 14'h0;
    push(1, 0, 0, ins, IRW);
    push(1, 0, 0, ins, 14'h0);
    push(1, 0, 0, ins, opf(op) | s);
    push(1, 0, 0, ins, RW | PCW | opf(op) | s);
    exp_ret = exp_ret + CW'(1);
  endtask

  task automatic push_lw(input int nwait);
    logic [31:0] ins = 32'h00802283;
    push(1, 0, 0, ins, IRW);
    push(1, 0, 0, ins, 14'h0);
    push(1, 0, 0, ins, opf(3'b010) | AS);
    for (int i = 0; i < nwait; i++) push(1, 0, 0, ins, MR | opf(3'b010) | AS);
    push(1, 0, 1, ins, MR | opf(3'b010) | AS);
    push(1, 0, 0, ins, RW | M2R | PCW | opf(3'b010) | AS);
    exp_ret = exp_ret + CW'(1);
  endtask

  task automatic push_sw(input int nwait);
    logic [31:0] ins = 32'h00502423;
    push(1, 0, 0, ins, IRW);
    push(1, 0, 0, ins, 14'h0);
    push(1, 0, 0, ins, opf(3'b010) | AS);
    for (int i = 0; i < nwait; i++) push(1, 0, 0, ins, MW | opf(3'b010) | AS);
    push(1, 0, 1, ins, MW | PCW | opf(3'b010) | AS);
    exp_ret = exp_ret + CW'(1);
  endtask

  task automatic push_3cyc(input logic [31:0] ins, input logic [13:0] ex);
    push(1, 0, 0, ins, IRW);
    push(1, 0, 0, ins, 14'h0);
    push(1, 0, 0, ins, ex);
  endtask

  task automatic push_ill(input logic [31:0] ins);
`ifdef Y_CTRL_TRAP_EN
    push_3cyc(ins, ILL | PCW | INTB);
`else
    push_3cyc(ins, ILL | PCW);
    exp_ret = exp_ret + CW'(1);
`endif
  endtask

  // Drives each queued stimulus cycle and captures the DUT response mid-cycle.
  task automatic run;
    stim_t s;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      @(posedge clk);
      #2;
      rst_n = s.rn;
      bus.int_req = s.irq;
      bus.mem_ready = s.mrdy;
      bus.ins = s.ins;
      #2;
      obs_q.push_back(obs);
    end
  endtask

  task automatic test_reset;
    obs_t e, o;
    push(0, 1, 1, 32'hFFFFFFFF, 14'h0);
    push(0, 1, 1, 32'h00802283, 14'h0);
    run();
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL reset cyc%0d got=%b exp=%b", i, o, e); end
    end
  endtask

  task automatic test_alu;
    obs_t e, o;
    push_alu(32'h002081B3, 3'b010, 1'b0);
    push_alu(32'h402081B3, 3'b110, 1'b0);
    push_alu(32'h0020F1B3, 3'b000, 1'b0);
    push_alu(32'h0020E1B3, 3'b001, 1'b0);
    push_alu(32'h0020A1B3, 3'b111, 1'b0);
    push_alu(32'h00500093, 3'b010, 1'b1);
    push_alu(32'h00507093, 3'b000, 1'b1);
    push_alu(32'h00506093, 3'b001, 1'b1);
    push_alu(32'h00502093, 3'b111, 1'b1);
    run();
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL alu cyc%0d got=%b exp=%b", i, o, e); end
    end
  endtask

  task automatic test_lw;
    obs_t e, o;
    push_lw(3);
    push_lw(0);
    run();
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL lw cyc%0d got=%b exp=%b", i, o, e); end
    end
  endtask

  task automatic test_back_to_back;
    obs_t e, o;
    bus.zero = 1'b1;
    push_sw(1);
    push_3cyc(32'h00208463, opf(3'b110) | BR | PCW);
    exp_ret = exp_ret + CW'(1);
    run();
    bus.zero = 1'b0;
    push_3cyc(32'h00208463, opf(3'b110) | BR | PCW);
    exp_ret = exp_ret + CW'(1);
    push_3cyc(32'h008000EF, JP | PCW);
    exp_ret = exp_ret + CW'(1);
    push_alu(32'h002081B3, 3'b010, 1'b0);
    run();
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL b2b cyc%0d got=%b exp=%b", i, o, e); end
    end
  endtask

  task automatic test_int;
    obs_t e, o;
    logic [31:0] ins = 32'h002081B3;
    push(1, 0, 0, ins, IRW);
    push(1, 1, 0, ins, 14'h0);
    push(1, 1, 0, ins, opf(3'b010));
    push(1, 1, 0, ins, RW | PCW | opf(3'b010));
    exp_ret = exp_ret + CW'(1);
    push(1, 1, 0, ins, INTB | PCW);
    push(1, 1, 0, ins, INTB | PCW);
    push_alu(ins, 3'b010, 1'b0);
    run();
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL int cyc%0d got=%b exp=%b", i, o, e); end
    end
  endtask

  task automatic test_illegal;
    obs_t e, o;
    push_ill(32'hFFFFFFFF);
    push_ill(32'h002091B3);
    push_ill(32'h00800283);
    push_alu(32'h002081B3, 3'b010, 1'b0);
    run();
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL illegal cyc%0d got=%b exp=%b", i, o, e); end
    end
  endtask

  task automatic test_reset_mem;
    obs_t e, o;
    logic [31:0] ins = 32'h00802283;
    push(1, 0, 0, ins, IRW);
    push(1, 0, 0, ins, 14'h0);
    push(1, 0, 0, ins, opf(3'b010) | AS);
    push(1, 0, 0, ins, MR | opf(3'b010) | AS);
    push(0, 1, 1, ins, 14'h0);
    exp_ret = '0;
    push(0, 1, 1, ins, 14'h0);
    push_alu(32'h002081B3, 3'b010, 1'b0);
    run();
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL rstmem cyc%0d got=%b exp=%b", i, o, e); end
    end
  endtask

  task automatic test_wrap;
    obs_t e, o;
    for (int n = 0; n < 2 * (1 << CW) && exp_ret != '1; n++) begin
      push_3cyc(32'h00208463, opf(3'b110) | BR | PCW);
      exp_ret = exp_ret + CW'(1);
    end
    push_3cyc(32'h00208463, opf(3'b110) | BR | PCW);
    exp_ret = exp_ret + CW'(1);
    push(1, 1, 0, 32'h00208463, INTB | PCW);
    run();
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL wrap cyc%0d got=%b exp=%b", i, o, e); end
    end
    checks++;
    if (bus.retired !== '0) begin
      errors++; $display("FAIL wrap_zero retired=%0d exp=0", bus.retired);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_lw();
    test_back_to_back();
    test_int();
    test_illegal();
    test_reset_mem();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end
endmodule
